// File: rtl/mnist_nn_pkg.sv
// Shared definitions for the MNIST neural-net compute engines.
//   - BRAM geometry (word address width, data width, int8 lanes per word)
//   - state_e : states of the BRAM dot-product engine FSM
//   - relu32  : optional clamp of a negative 32-bit result to zero
package mnist_nn_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 32;
  localparam int INT8_LANES  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_X  = 3'd1,
    RD_W  = 3'd2,
    LAST  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [31:0] relu32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? 32'h0 : v;
  endfunction

endpackage

// File: rtl/dot4_int8.sv
// Packed int8 dot product: four signed int8 lanes of a_i times the matching
// lanes of b_i, summed and sign-extended to 32 bits. Purely combinational.
//   a_i   [31:0] in  : four signed int8 lanes, lane k = bits [8k+7:8k]
//   b_i   [31:0] in  : four signed int8 lanes
//   sum_o [31:0] out : signed sum of the four lane products
module dot4_int8
  import mnist_nn_pkg::*;
(
  input  logic        [31:0] a_i,
  input  logic        [31:0] b_i,
  output logic signed [31:0] sum_o
);

  logic signed [15:0] prod [INT8_LANES];

  // An int8 x int8 product always fits in 16 signed bits, so operands are
  // sign-extended to 16 bits and the product is kept at 16 bits.
  for (genvar k = 0; k < INT8_LANES; k++) begin : g_lane
    assign prod[k] = 16'($signed(a_i[8*k +: 8])) * 16'($signed(b_i[8*k +: 8]));
  end

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < INT8_LANES; k++) begin
      sum_o = sum_o + 32'(prod[k]);
    end
  end

endmodule

// File: rtl/bram_dot_product_engine.sv
// Per-neuron dot-product engine on native BRAM port B.
// On start it reads len_words input words and len_words weight words
// (interleaved x,w,x,w,...), accumulates the packed int8 dot product into a
// wrapping 32-bit accumulator, optionally applies ReLU, writes the result to
// out_addr and pulses done.
//
// Handshake: start is a one-cycle request honoured only in IDLE (ignored
// while busy). busy is high from the cycle after acceptance up to and
// including the done cycle; done pulses for exactly one cycle once the
// result word has been written. result holds its value until the next done.
//
// Ports:
//   s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//   start, in_base, w_base, len_words, out_addr, relu_en : job request
//   busy, done, result       : job status
//   BRAM_PORTB_*             : native BRAM port B (read data 1 cycle after en)
//   dbg_state_o              : current FSM state, for observation only
module bram_dot_product_engine
  import mnist_nn_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int LEN_W  = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] BRAM_PORTB_addr,
  output logic [DATA_W-1:0] BRAM_PORTB_din,
  input  logic [DATA_W-1:0] BRAM_PORTB_dout,
  output logic              BRAM_PORTB_en,
  output logic [3:0]        BRAM_PORTB_we,
  output logic              BRAM_PORTB_rst,
  output state_e            dbg_state_o
);

  state_e             state_q;
  logic [ADDR_W-1:0]  in_base_q;
  logic [ADDR_W-1:0]  w_base_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic               relu_q;
  logic [LEN_W-1:0]   idx_q;
  logic [31:0]        acc_q;
  logic [DATA_W-1:0]  x_q;

  // Registered port-B and status outputs.
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;
  logic               en_q;
  logic [3:0]         we_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        result_q;

  logic signed [31:0] dot_sum;
  logic [31:0]        acc_d;
  logic [LEN_W-1:0]   idx_inc;

  // Port-B read data is the weight word paired with x_q whenever it is used.
  dot4_int8 u_dot4 (
    .a_i   (x_q),
    .b_i   (BRAM_PORTB_dout),
    .sum_o (dot_sum)
  );

  assign acc_d   = acc_q + dot_sum;
  assign idx_inc = idx_q + LEN_W'(1);

  // Outputs are registered, so each transition programs the port-B outputs
  // for the state being entered.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q    <= IDLE;
      in_base_q  <= '0;
      w_base_q   <= '0;
      len_q      <= '0;
      out_addr_q <= '0;
      relu_q     <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      en_q       <= 1'b0;
      we_q       <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      en_q   <= 1'b0;
      we_q   <= 4'h0;
      din_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            in_base_q  <= in_base;
            w_base_q   <= w_base;
            len_q      <= len_words;
            out_addr_q <= out_addr;
            relu_q     <= relu_en;
            acc_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            en_q       <= 1'b1;
            if (len_words == '0) begin
              // Empty vector: write a zero result straight away.
              state_q <= WRITE;
              we_q    <= 4'hF;
              addr_q  <= out_addr;
            end else begin
              state_q <= RD_X;
              addr_q  <= in_base;
            end
          end
        end
        RD_X: begin
          // dout holds w[i-1] from the previous RD_W read.
          if (idx_q != '0) begin
            acc_q <= acc_d;
          end
          state_q <= RD_W;
          en_q    <= 1'b1;
          addr_q  <= w_base_q + ADDR_W'(idx_q);
        end
        RD_W: begin
          x_q   <= BRAM_PORTB_dout;
          idx_q <= idx_inc;
          if (idx_inc == len_q) begin
            state_q <= LAST;
          end else begin
            state_q <= RD_X;
            en_q    <= 1'b1;
            addr_q  <= in_base_q + ADDR_W'(idx_inc);
          end
        end
        LAST: begin
          acc_q   <= acc_d;
          state_q <= WRITE;
          en_q    <= 1'b1;
          we_q    <= 4'hF;
          addr_q  <= out_addr_q;
          din_q   <= relu32(acc_d, relu_q);
        end
        WRITE: begin
          result_q <= din_q;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign BRAM_PORTB_addr = addr_q;
  assign BRAM_PORTB_din  = din_q;
  assign BRAM_PORTB_en   = en_q;
  assign BRAM_PORTB_we   = we_q;
  assign BRAM_PORTB_rst  = s_axi_areset;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/bram_dot_product_engine.md
Name: bram_dot_product_engine

Overview:
- Sits on native BRAM port B of the dual-port AXI/native BRAM. The PS loads input vectors and weights through the AXI-Lite side.
- On a start pulse, the engine reads an input vector and a weight vector over port B. Each 32-bit word packs 4 signed int8 lanes.
- It accumulates the dot product into 32 bits, applies optional ReLU, and writes the result back to BRAM.
- This is the per-neuron compute stage of the MNIST net.

Parameters:
- ADDR_W, 10, BRAM word-address width (1024 words).
- DATA_W, 32, BRAM data width. Fixed at 32 (4 int8 lanes); other values are unsupported.
- LEN_W, 8, width of the vector-length field (words).

Ports:
- s_axi_aclk  in  1  the single clock; also drives BRAM port B.
- s_axi_areset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_base  in  ADDR_W  word address of input vector.
- w_base  in  ADDR_W  word address of weight vector.
- len_words  in  LEN_W  vector length in 32-bit words.
- out_addr  in  ADDR_W  destination word address for the result.
- relu_en  in  1  clamp negative result to 0.
- busy  out  1  engine active.
- done  out  1  one-cycle pulse when the result has been written.
- result  out  32  last result, signed, held until next done.
- BRAM_PORTB_addr  out  ADDR_W  port-B word address.
- BRAM_PORTB_din  out  DATA_W  port-B write data.
- BRAM_PORTB_dout  in  DATA_W  port-B read data, valid 1 cycle after en.
- BRAM_PORTB_en  out  1  port-B enable.
- BRAM_PORTB_we  out  4  port-B byte write enables.
- BRAM_PORTB_rst  out  1  tied to s_axi_areset.

Behaviour:
- Clock and reset: one clock, s_axi_aclk; reset s_axi_areset is synchronous, active-high.
- Reset values: all outputs 0. Reset also clears state (IDLE), acc, x_reg and index.
- Reset mid-operation: the next cycle has en=0, we=0, busy=0, and no write is issued.
- Start capture: on start in IDLE, latch in_base, w_base, len_words, out_addr, relu_en; clear acc and index i.
  - start while busy is ignored.
  - start and done in the same cycle is impossible, since done is only driven outside IDLE.
- States:
  - IDLE: start goes to RD_X, or to WRITE if len_words==0.
  - RD_X: en=1, addr=in_base+i. If i>0, capture dout as w[i-1] and acc += dot4(x_reg, w). Go to RD_W.
  - RD_W: en=1, addr=w_base+i, x_reg<=dout. Then i++; go to LAST if i+1==len, else RD_X.
  - LAST: en=0; capture final w and accumulate. Go to WRITE.
  - WRITE: en=1, we=4'hF, addr=out_addr, din=final value, result<=final value. Go to DONE.
  - DONE: done=1, en=0. Go to IDLE.
- Final value: relu_en && acc[31] ? 0 : acc.
- Addresses: base+i modulo 2^ADDR_W (wrap-around, no error).
- dot4: lane k = bits [8k+7:8k], signed int8 × signed int8 → 16-bit; the sum of 4 lanes is sign-extended to 32 bits.
- acc: 32-bit two's-complement, wraps on overflow with no saturation.
- Timing with start accepted at cycle T and length L≥1:
  - read pairs occupy T+1..T+2L; LAST at T+2L+1; WRITE at T+2L+2; done at T+2L+3.
  - busy is high T+1..T+2L+3.
- Timing with L=0: WRITE at T+1, done at T+2, result=0.
- we is nonzero only in WRITE; din is 0 outside WRITE.

Decomposition:
- Package mnist_nn_pkg:
  - state enum {IDLE, RD_X, RD_W, LAST, WRITE, DONE}
  - BRAM_ADDR_W=10, BRAM_DATA_W=32, INT8_LANES=4.
- One combinational sub-module, dot4_int8 (a: 32, b: 32 → sum: 32 signed), reused by later layer engines.

Test Plan:
- Basic: L=1, mem[0x000]=0x01020304, mem[0x100]=0x01010101, out_addr=0x200. Required: result=10 and mem[0x200]=0x0000000A, done at T+5, busy high T+1..T+5.
- Signed lanes: x=0x80808080, w=0x7F7F7F7F, L=1. Required: result=0xFFFF0200 (−65024). Same with relu_en=1: result=0 and 0 written.
- Zero length: L=0. Required: en low at T+1 except the write, write of 0 to out_addr at T+1, done at T+2.
- Address wrap: in_base=0x3FF, w_base=0x3FE, L=2. Required: port-B read address sequence 0x3FF, 0x3FE, 0x000, 0x3FF, and the correct sum.
- Reset in RD_W: assert s_axi_areset during a run. Required: next cycle busy=0, en=0, we=0, no write to out_addr. A subsequent start completes normally.
- Start while busy: a second start mid-run is ignored, yielding exactly one done. A start in the cycle after done is accepted.
